// File: rtl/baud_generator_frac_if.sv
// Interface bundle for baud_generator_frac.
// Purpose: groups the divisor control inputs and the tick outputs of the
// fractional baud generator so the consumer (UART RX/TX glue) and the
// generator share one port.
// Signals:
//   en         count enable; 0 freezes the generator (no ticks)
//   restart    phase restart; clears counters, no tick that cycle
//   dvsr_int   integer divisor N (valid N >= 2)
//   dvsr_frac  fractional divisor F (resolution 1/2^FRAC_WIDTH)
//   s_tick     oversample tick, average period N + F/2^FRAC_WIDTH clks
//   mid_tick   coincident with the s_tick at mid-bit
//   bit_tick   coincident with the last s_tick of a bit
//   dvsr_err   1 while the latched N is below 2
// Handshake: there is no valid/ready pair. en and restart are level
// controls sampled on every rising clock edge; the ticks are single-cycle
// registered pulses that the consumer must sample on the edge where they
// are high (they are never held or re-sent).
interface baud_generator_frac_if #(
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4
);
  logic                  en;
  logic                  restart;
  logic [INT_WIDTH-1:0]  dvsr_int;
  logic [FRAC_WIDTH-1:0] dvsr_frac;
  logic                  s_tick;
  logic                  mid_tick;
  logic                  bit_tick;
  logic                  dvsr_err;

  // Consumer side: drives the divisor and controls, receives ticks.
  modport master (
    output en, restart, dvsr_int, dvsr_frac,
    input  s_tick, mid_tick, bit_tick, dvsr_err
  );

  // Generator side.
  modport slave (
    input  en, restart, dvsr_int, dvsr_frac,
    output s_tick, mid_tick, bit_tick, dvsr_err
  );
endinterface

// File: rtl/baud_generator_frac.sv
// Fractional-N baud tick generator.
// Purpose: divides clk by dvsr_int + dvsr_frac/2^FRAC_WIDTH to produce an
// oversample tick, plus a per-bit tick and a mid-bit tick derived from an
// oversample counter. Periods are N or N+1 clks, with the N+1 periods spread
// evenly by a first-order fractional accumulator.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high; clears all state and outputs
//   bus    baud_generator_frac_if.slave (en, restart, dvsr_int, dvsr_frac
//          in; s_tick, mid_tick, bit_tick, dvsr_err out)
// Priority per edge: reset > divisor change > restart > en.
module baud_generator_frac #(
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4,
  parameter int OVS        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  baud_generator_frac_if.slave   bus
);

  localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

  logic [INT_WIDTH-1:0]  cnt_q,     cnt_d;
  logic [INT_WIDTH-1:0]  limit_q,   limit_d;
  logic [FRAC_WIDTH-1:0] acc_q,     acc_d;
  logic [OVS_W-1:0]      ovs_cnt_q, ovs_cnt_d;
  logic [INT_WIDTH-1:0]  int_q,     int_d;
  logic [FRAC_WIDTH-1:0] frac_q,    frac_d;
  logic                  s_tick_q,   s_tick_d;
  logic                  mid_tick_q, mid_tick_d;
  logic                  bit_tick_q, bit_tick_d;
  logic                  dvsr_err_q, dvsr_err_d;

  logic                  div_change;
  logic                  int_ok;
  logic                  at_limit;
  logic [FRAC_WIDTH:0]   frac_sum;

  // Any difference between the live divisor and the latched copy is a
  // divisor change. After reset the latched copy is zero, so the first
  // non-zero divisor seen is the change that starts counting.
  assign div_change = ({bus.dvsr_int, bus.dvsr_frac} != {int_q, frac_q});

  // Counting is only allowed with a latched N >= 2. Checking the latched
  // divisor rather than dvsr_err_q also blocks counting straight after
  // reset, when the latched N is 0 but dvsr_err is still cleared.
  assign int_ok   = (int_q >= INT_WIDTH'(2));
  assign at_limit = (cnt_q == limit_q);

  // Accumulator plus fraction; the top bit is the carry that stretches the
  // next period by one clock.
  assign frac_sum = {1'b0, acc_q} + {1'b0, frac_q};

  always_comb begin
    cnt_d      = cnt_q;
    limit_d    = limit_q;
    acc_d      = acc_q;
    ovs_cnt_d  = ovs_cnt_q;
    int_d      = int_q;
    frac_d     = frac_q;
    dvsr_err_d = dvsr_err_q;
    s_tick_d   = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;

    if (div_change) begin
      int_d      = bus.dvsr_int;
      frac_d     = bus.dvsr_frac;
      cnt_d      = '0;
      acc_d      = '0;
      ovs_cnt_d  = '0;
      // First period after a change is exactly N clocks (no carry yet).
      limit_d    = bus.dvsr_int - INT_WIDTH'(1);
      dvsr_err_d = (bus.dvsr_int < INT_WIDTH'(2));
    end else if (bus.restart) begin
      cnt_d     = '0;
      acc_d     = '0;
      ovs_cnt_d = '0;
      limit_d   = int_q - INT_WIDTH'(1);
    end else if (bus.en && int_ok) begin
      if (!at_limit) begin
        cnt_d = cnt_q + INT_WIDTH'(1);
      end else begin
        s_tick_d   = 1'b1;
        mid_tick_d = (ovs_cnt_q == OVS_MID);
        bit_tick_d = (ovs_cnt_q == OVS_LAST);
        cnt_d      = '0;
        acc_d      = frac_sum[FRAC_WIDTH-1:0];
        // limit = N-1+c never wraps: at most N-1+1 = N.
        limit_d    = int_q - INT_WIDTH'(1) + INT_WIDTH'(frac_sum[FRAC_WIDTH]);
        ovs_cnt_d  = (ovs_cnt_q == OVS_LAST) ? '0 : ovs_cnt_q + OVS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      limit_q    <= '0;
      acc_q      <= '0;
      ovs_cnt_q  <= '0;
      int_q      <= '0;
      frac_q     <= '0;
      dvsr_err_q <= 1'b0;
      s_tick_q   <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      acc_q      <= acc_d;
      ovs_cnt_q  <= ovs_cnt_d;
      int_q      <= int_d;
      frac_q     <= frac_d;
      dvsr_err_q <= dvsr_err_d;
      s_tick_q   <= s_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign bus.s_tick   = s_tick_q;
  assign bus.mid_tick = mid_tick_q;
  assign bus.bit_tick = bit_tick_q;
  assign bus.dvsr_err = dvsr_err_q;

endmodule

// File: tb/tb_baud_generator_frac.sv
// Testbench for baud_generator_frac: table-driven period vectors, directed
// corner-case sequences and a randomized run, all checked cycle by cycle
// against a closed-form tick-time model.
module tb_baud_generator_frac;

  localparam int INT_W = 16;
  localparam int FW    = 4;
  localparam int OVS   = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  baud_generator_frac_if #(.INT_WIDTH(INT_W), .FRAC_WIDTH(FW)) bif ();

  baud_generator_frac #(.INT_WIDTH(INT_W), .FRAC_WIDTH(FW), .OVS(OVS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // ---------------- scoreboard counters ----------------
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Tick k (k = 1,2,...) after a phase start occurs on enabled counting edge
  // T(k) = k*N + floor((k-1)*F / 2^FW): the first period is exactly N and
  // the fractional remainder is distributed across later periods.
  logic [INT_W-1:0] m_int;
  logic [FW-1:0]    m_frac;
  bit               m_err;
  longint           m_e;     // enabled counting edges since phase start
  longint           m_k;     // index of the next expected tick
  bit               exp_s, exp_m, exp_b;

  function automatic longint t_of(input longint k);
    return k * longint'(m_int) + (((k - 1) * longint'(m_frac)) >>> FW);
  endfunction

  task automatic model_edge();
    exp_s = 1'b0;
    exp_m = 1'b0;
    exp_b = 1'b0;
    if (reset) begin
      m_int = '0; m_frac = '0; m_err = 1'b0; m_e = 0; m_k = 1;
    end else if (bif.dvsr_int != m_int || bif.dvsr_frac != m_frac) begin
      m_int  = bif.dvsr_int;
      m_frac = bif.dvsr_frac;
      m_err  = (bif.dvsr_int < 2);
      m_e    = 0;
      m_k    = 1;
    end else if (bif.restart) begin
      m_e = 0;
      m_k = 1;
    end else if (bif.en && m_int >= 2) begin
      m_e++;
      if (m_e == t_of(m_k)) begin
        exp_s = 1'b1;
        exp_m = ((m_k % OVS) == OVS / 2);
        exp_b = ((m_k % OVS) == 0);
        m_k++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: inputs already set; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    check("s_tick",   bif.s_tick,   exp_s);
    check("mid_tick", bif.mid_tick, exp_m);
    check("bit_tick", bif.bit_tick, exp_b);
    check("dvsr_err", bif.dvsr_err, m_err);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset, then apply divisor; returns the cycle of the change edge E0.
  task automatic start(input int n, input int f, output longint t0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bif.dvsr_int  = INT_W'(n);
    bif.dvsr_frac = FW'(f);
    bif.en        = 1'b1;
    bif.restart   = 1'b0;
    step();
    t0 = cyc;
  endtask

  // sel: 0 = s_tick, 1 = mid_tick, 2 = bit_tick
  task automatic wait_sig(input int sel, input int budget, output longint at);
    bit seen;
    bit hit;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      hit = (sel == 0) ? bif.s_tick : (sel == 1) ? bif.mid_tick : bif.bit_tick;
      if (hit) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check("wait_in_budget", seen, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n;
    int f;
    int ticks;      // intervals measured after the first tick
    int exp_first;  // E0 -> first tick
    int exp_sum;    // first tick -> tick (1+ticks)
  } vec_t;

  vec_t vecs[6];

  initial begin
    longint t0, t1, t2, tb, tm;
    int     cnt;

    vecs[0] = '{n: 10, f: 0,  ticks: 32, exp_first: 10, exp_sum: 320};
    vecs[1] = '{n: 10, f: 8,  ticks: 32, exp_first: 10, exp_sum: 336};
    vecs[2] = '{n: 27, f: 2,  ticks: 8,  exp_first: 27, exp_sum: 217};
    vecs[3] = '{n: 3,  f: 0,  ticks: 10, exp_first: 3,  exp_sum: 30};
    vecs[4] = '{n: 2,  f: 15, ticks: 16, exp_first: 2,  exp_sum: 47};
    vecs[5] = '{n: 5,  f: 1,  ticks: 16, exp_first: 5,  exp_sum: 81};

    reset         = 1'b1;
    bif.en        = 1'b0;
    bif.restart   = 1'b0;
    bif.dvsr_int  = '0;
    bif.dvsr_frac = '0;
    m_int = '0; m_frac = '0; m_err = 1'b0; m_e = 0; m_k = 1;

    // Reset state
    step();
    check("rst_s_tick",   bif.s_tick,   0);
    check("rst_mid_tick", bif.mid_tick, 0);
    check("rst_bit_tick", bif.bit_tick, 0);
    check("rst_dvsr_err", bif.dvsr_err, 0);

    // Table-driven period vectors
    foreach (vecs[i]) begin
      start(vecs[i].n, vecs[i].f, t0);
      wait_sig(0, 100, t1);
      check("vec_first_period", t1 - t0, vecs[i].exp_first);
      t2 = t1;
      for (int k = 0; k < vecs[i].ticks; k++) wait_sig(0, 100, t2);
      check("vec_sum_periods", t2 - t1, vecs[i].exp_sum);
    end

    // bit_tick every 160 clks, mid_tick 80 clks after each bit_tick
    start(10, 0, t0);
    wait_sig(1, 200, tm);
    check("first_mid", tm - t0, 80);
    wait_sig(2, 200, tb);
    check("first_bit", tb - t0, 160);
    wait_sig(1, 200, tm);
    check("mid_after_bit", tm - tb, 80);
    wait_sig(2, 200, t1);
    check("bit_spacing", t1 - tb, 160);

    // Divisor change 10 -> 20 mid-period
    start(10, 0, t0);
    wait_sig(0, 50, t1);
    steps(5);
    bif.dvsr_int = 16'd20;
    step();
    check("chg_no_tick", bif.s_tick, 0);
    t0 = cyc;
    wait_sig(0, 50, t1);
    check("chg_next_tick", t1 - t0, 20);
    wait_sig(1, 400, tm);
    check("chg_ovs_restart", tm - t0, 160);

    // en pause of 7 clks at cnt=4, then restart at cnt=8
    start(10, 0, t0);
    wait_sig(0, 50, t1);
    steps(4);
    bif.en = 1'b0;
    steps(7);
    bif.en = 1'b1;
    wait_sig(0, 50, t2);
    check("pause_period", t2 - t1, 17);
    steps(8);
    bif.restart = 1'b1;
    step();
    check("restart_no_tick", bif.s_tick, 0);
    t0 = cyc;
    bif.restart = 1'b0;
    wait_sig(0, 50, t1);
    check("restart_period", t1 - t0, 10);

    // Invalid divisor N=1, then recovery to N=3
    reset = 1'b1;
    step();
    reset = 1'b0;
    bif.dvsr_int  = 16'd1;
    bif.dvsr_frac = '0;
    bif.en        = 1'b1;
    step();
    check("err_set", bif.dvsr_err, 1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bif.s_tick || bif.mid_tick || bif.bit_tick) cnt++;
    end
    check("err_no_ticks", cnt, 0);
    bif.dvsr_int = 16'd3;
    step();
    check("err_clear", bif.dvsr_err, 0);
    t0 = cyc;
    wait_sig(0, 20, t1);
    check("n3_first", t1 - t0, 3);
    wait_sig(0, 20, t2);
    check("n3_period", t2 - t1, 3);

    // Reset on the edge where a tick was due
    start(10, 0, t0);
    wait_sig(0, 50, t1);
    steps(9);
    reset = 1'b1;
    step();
    check("midrun_rst_s",   bif.s_tick,   0);
    check("midrun_rst_mid", bif.mid_tick, 0);
    check("midrun_rst_bit", bif.bit_tick, 0);
    check("midrun_rst_err", bif.dvsr_err, 0);
    reset = 1'b0;

    // Randomized run against the model
    bif.dvsr_int  = 16'd7;
    bif.dvsr_frac = 4'd5;
    for (int i = 0; i < 6000; i++) begin
      reset       = ($urandom_range(0, 999) == 0);
      bif.restart = ($urandom_range(0, 149) == 0);
      bif.en      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) begin
        bif.dvsr_int  = INT_W'($urandom_range(0, 12));
        bif.dvsr_frac = FW'($urandom_range(0, 15));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
